alu_cmd_queue: RTL

ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

---
 rtl/alu_cmd_queue.sv | 134 +++++++++++++
 1 files changed

// File: rtl/alu_cmd_queue.sv
// Command queue in front of a registered simple_alu: buffers {a,b,op}, issues one
// command at a time, captures the ALU result and presents it on a response port.
module alu_cmd_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [7:0]             cmd_a,
  input  logic [7:0]             cmd_b,
  input  logic [2:0]             cmd_op,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [2:0]             alu_opcode,
  input  logic [15:0]            alu_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [15:0]            rsp_data,
  output logic [2:0]             rsp_op,
  output logic                   rsp_err,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t        state;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] head;
  logic          not_empty;
  logic          push;
  logic          pop;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; a producer holding valid keeps its payload stable until that edge.
  assign cmd_ready = !rst && (count != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign not_empty = (count != '0);
  assign pop       = not_empty && ((state == IDLE) || ((state == HOLD) && rsp_ready));
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The ALU samples alu_* at the edge closing EXEC; its registered result is
  // therefore valid throughout CAPT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_op     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            alu_a      <= head[18:11];
            alu_b      <= head[10:3];
            alu_opcode <= head[2:0];
            state      <= EXEC;
          end
        end
        EXEC: state <= CAPT;
        CAPT: begin
          rsp_data  <= alu_result;
          rsp_op    <= alu_opcode;
          rsp_err   <= (alu_opcode == 3'b111);
          rsp_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (pop) begin
              alu_a      <= head[18:11];
              alu_b      <= head[10:3];
              alu_opcode <= head[2:0];
              state      <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));

  a_rsp_in_hold: assert property (@(posedge clk) disable iff (rst)
    rsp_valid == (state == HOLD));

  a_err_tracks_op: assert property (@(posedge clk) disable iff (rst)
    rsp_err == (rsp_op == 3'b111));

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_op)
                                   && $stable(rsp_err)));

endmodule
